// File: rtl/sub_word_store_scheduler.sv
// Read-modify-write sequencer for SB/SH stores on a word-wide data bus.
// Reads the aligned word, merges the byte/half lane, writes it back.
module sub_word_store_scheduler #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_half,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   data_q, data_d;
    logic          half_q, half_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   merged;
    logic          timeout;
    logic          unused_data;

    assign unused_data = ^req_data[31:16];

    assign timeout = (WAIT_MAX != 0) && (cnt_q == CW'(WAIT_MAX - 1));

    always_comb begin
        merged = rdata_q;
        if (half_q) begin
            if (lane_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end else begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        data_d  = data_q;
        half_d  = half_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    lane_d = req_addr[1:0];
                    data_d = req_data[15:0];
                    half_d = req_half;
                    cnt_d  = '0;
                    if (req_half && req_addr[0]) begin
                        state_d = S_FAULT;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_RD;
                        rd_d    = 1'b1;
                        addr_d  = {req_addr[31:2], 2'b00};
                    end
                end
            end
            S_RD: begin
                if (!mem_waitrequest) begin
                    rdata_d = mem_readdata;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_MERGE;
                end else if (timeout) begin
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FAULT;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else if (WAIT_MAX != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MERGE: begin
                wdata_d = merged;
                wr_d    = 1'b1;
                state_d = S_WR;
            end
            S_WR: begin
                if (!mem_waitrequest) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (timeout) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FAULT;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else if (WAIT_MAX != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only the pipeline-hold is combinational; every bus strobe is a flop.
    assign stall = ((state_q == S_IDLE) && req_valid)
                 || (state_q == S_RD)
                 || (state_q == S_MERGE)
                 || (state_q == S_WR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            half_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            half_q  <= half_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign done          = done_q;
    assign fault         = fault_q;
    assign mem_address   = addr_q;
    assign mem_read      = rd_q;
    assign mem_write     = wr_q;
    assign mem_writedata = wdata_q;

endmodule

// File: tb/tb_sub_word_store_scheduler.sv
// Directed bench for the SB/SH read-modify-write scheduler.
// Each cycle inputs are driven at the falling edge and outputs sampled 1ns later.
module tb_sub_word_store_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_half;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        stall;
    logic        done;
    logic        fault;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    always #5 clk = ~clk;

    sub_word_store_scheduler #(.WAIT_MAX(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_half        (req_half),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .stall           (stall),
        .done            (done),
        .fault           (fault),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    logic        st_a [32];
    logic        rd_a [32];
    logic        wr_a [32];
    logic        dn_a [32];
    logic        ft_a [32];
    logic [31:0] ad_a [32];
    logic [31:0] wd_a [32];

    // Request in cycle 0 only; req_* scrambled afterwards. A simple bus
    // model holds waitrequest for rdw read cycles and wrw write cycles.
    task automatic run(input logic half, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] rdata,
                       input int rdw, input int wrw, input int n,
                       input int rst_at);
        int rc = 0;
        int wc = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset     = (c == rst_at) ? 1'b0 : 1'b1;
            req_valid = (c == 0);
            req_half  = (c == 0) ? half : ~half;
            req_addr  = (c == 0) ? addr : ~addr;
            req_data  = (c == 0) ? data : ~data;
            mem_waitrequest = 1'b0;
            if (mem_read) begin
                mem_waitrequest = (rc < rdw);
                rc++;
            end
            if (mem_write) begin
                mem_waitrequest = (wc < wrw);
                wc++;
            end
            mem_readdata = (mem_read && !mem_waitrequest) ? rdata : ~rdata;
            #1;
            st_a[c] = stall;
            rd_a[c] = mem_read;
            wr_a[c] = mem_write;
            dn_a[c] = done;
            ft_a[c] = fault;
            ad_a[c] = mem_address;
            wd_a[c] = mem_writedata;
        end
        req_valid       = 1'b0;
        reset           = 1'b1;
        mem_waitrequest = 1'b0;
    endtask

    task automatic test_reset;
        reset           = 1'b0;
        req_valid       = 1'b0;
        req_half        = 1'b0;
        req_addr        = 32'h0;
        req_data        = 32'h0;
        mem_readdata    = 32'h0;
        mem_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({stall, done, fault, mem_read, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000",
                     {stall, done, fault, mem_read, mem_write});
        end
        checks++;
        if (mem_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h exp 0", mem_address);
        end
        checks++;
        if (mem_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_wdata got %h exp 0", mem_writedata);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_merge;
        logic        h  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] a  [6] = '{32'h1003, 32'h1000, 32'h1001,
                                32'h2002, 32'h2000, 32'h1006};
        logic [31:0] d  [6] = '{32'hAB, 32'hCD, 32'h5A,
                                32'hBEEF, 32'hBEEF, 32'hFFFFFF99};
        logic [31:0] r  [6] = '{32'h11223344, 32'h11223344, 32'h11223344,
                                32'hDEADC0DE, 32'hDEADC0DE, 32'h11223344};
        logic [31:0] e  [6] = '{32'hAB223344, 32'h112233CD, 32'h11225A44,
                                32'hBEEFC0DE, 32'hDEADBEEF, 32'h11993344};
        logic [31:0] ea [6] = '{32'h1000, 32'h1000, 32'h1000,
                                32'h2000, 32'h2000, 32'h1004};
        for (int i = 0; i < 6; i++) begin
            run(h[i], a[i], d[i], r[i], 0, 0, 7, -1);
            checks++;
            if (wd_a[3] !== e[i] || wr_a[3] !== 1'b1) begin
                errors++;
                $display("FAIL merge%0d wdata got %h/%b exp %h/1",
                         i, wd_a[3], wr_a[3], e[i]);
            end
            checks++;
            if (ad_a[3] !== ea[i] || ad_a[1] !== ea[i]) begin
                errors++;
                $display("FAIL merge%0d addr got %h,%h exp %h",
                         i, ad_a[1], ad_a[3], ea[i]);
            end
            checks++;
            if ({dn_a[3], dn_a[4], ft_a[4], dn_a[5]} !== 4'b0100) begin
                errors++;
                $display("FAIL merge%0d done got %b exp 0100", i,
                         {dn_a[3], dn_a[4], ft_a[4], dn_a[5]});
            end
        end
        // Timing of the first case repeated for the full cycle profile
        run(1'b0, 32'h1003, 32'hAB, 32'h11223344, 0, 0, 6, -1);
        checks++;
        if ({st_a[0], st_a[1], st_a[2], st_a[3], st_a[4], st_a[5]}
            !== 6'b111100) begin
            errors++;
            $display("FAIL sb_stall got %b exp 111100",
                     {st_a[0], st_a[1], st_a[2], st_a[3], st_a[4], st_a[5]});
        end
        checks++;
        if ({rd_a[0], rd_a[1], rd_a[2], rd_a[3], rd_a[4]} !== 5'b01000 ||
            {wr_a[0], wr_a[1], wr_a[2], wr_a[3], wr_a[4]} !== 5'b00010) begin
            errors++;
            $display("FAIL sb_strobes got rd %b wr %b exp 01000 00010",
                     {rd_a[0], rd_a[1], rd_a[2], rd_a[3], rd_a[4]},
                     {wr_a[0], wr_a[1], wr_a[2], wr_a[3], wr_a[4]});
        end
    endtask

    task automatic test_waits;
        int bad;
        int dc;
        run(1'b0, 32'h4002, 32'h77, 32'hAABBCCDD, 3, 2, 12, -1);
        bad = 0;
        dc  = -1;
        for (int c = 1; c <= 8; c++)
            if (ad_a[c] !== 32'h4000) bad++;
        for (int c = 1; c <= 4; c++)
            if (rd_a[c] !== 1'b1) bad++;
        for (int c = 6; c <= 8; c++)
            if (wr_a[c] !== 1'b1 || wd_a[c] !== 32'hAA77CCDD) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_stable got %0d unstable exp 0", bad);
        end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd_a[c] && wr_a[c]) bad++;
            if (dn_a[c] && dc < 0) dc = c;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wait_overlap got %0d exp 0", bad);
        end
        checks++;
        if (dc != 9 || ft_a[9] !== 1'b0) begin
            errors++;
            $display("FAIL wait_done got cycle %0d fault %b exp 9 0",
                     dc, ft_a[9]);
        end
        // Counter must clear between phases: 3 + 3 waits stay under limit 4
        run(1'b1, 32'h4000, 32'h1234, 32'hAABBCCDD, 3, 3, 12, -1);
        checks++;
        if (dn_a[10] !== 1'b1 || ft_a[10] !== 1'b0 ||
            wd_a[9] !== 32'hAABB1234) begin
            errors++;
            $display("FAIL wait_clear got done %b fault %b wd %h exp 1 0 aabb1234",
                     dn_a[10], ft_a[10], wd_a[9]);
        end
    endtask

    task automatic test_misaligned;
        int strobes = 0;
        run(1'b1, 32'h3001, 32'hBEEF, 32'h0, 0, 0, 6, -1);
        for (int c = 0; c < 6; c++)
            if (rd_a[c] || wr_a[c]) strobes++;
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL misal_strobe got %0d exp 0", strobes);
        end
        checks++;
        if ({dn_a[1], ft_a[1], dn_a[2], ft_a[2]} !== 4'b1100) begin
            errors++;
            $display("FAIL misal_fault got %b exp 1100",
                     {dn_a[1], ft_a[1], dn_a[2], ft_a[2]});
        end
        checks++;
        if ({st_a[0], st_a[1], st_a[2]} !== 3'b100) begin
            errors++;
            $display("FAIL misal_stall got %b exp 100",
                     {st_a[0], st_a[1], st_a[2]});
        end
    endtask

    task automatic test_timeout;
        int nrd = 0;
        run(1'b0, 32'h5001, 32'h11, 32'h0, 100, 0, 8, -1);
        for (int c = 0; c < 8; c++)
            if (rd_a[c]) nrd++;
        checks++;
        if (nrd != 4 || rd_a[4] !== 1'b1 || rd_a[5] !== 1'b0) begin
            errors++;
            $display("FAIL tmo_read got %0d cycles exp 4", nrd);
        end
        checks++;
        if ({dn_a[5], ft_a[5], dn_a[6], st_a[5]} !== 4'b1100) begin
            errors++;
            $display("FAIL tmo_fault got %b exp 1100",
                     {dn_a[5], ft_a[5], dn_a[6], st_a[5]});
        end
        run(1'b0, 32'h5001, 32'h11, 32'h99887766, 0, 0, 6, -1);
        checks++;
        if (wd_a[3] !== 32'h99881166 || dn_a[4] !== 1'b1 ||
            ft_a[4] !== 1'b0) begin
            errors++;
            $display("FAIL tmo_recover got %h done %b fault %b exp 99881166 1 0",
                     wd_a[3], dn_a[4], ft_a[4]);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        run(1'b0, 32'h6000, 32'h42, 32'h0, 0, 100, 8, 4);
        checks++;
        if (wr_a[4] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre got wr %b exp 1", wr_a[4]);
        end
        for (int c = 5; c < 8; c++)
            if ({st_a[c], dn_a[c], ft_a[c], rd_a[c], wr_a[c]} !== 5'b0 ||
                ad_a[c] !== 32'h0 || wd_a[c] !== 32'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rstmid_outs got %0d bad cycles exp 0", bad);
        end
    endtask

    initial begin
        test_reset;
        test_merge;
        test_waits;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
